run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Sequencer that sits directly upstream of the processor top level.
- Preloads the processor's data memory from a byte stream and holds the core in reset while loading.
- Releases the core, counts cycles until the core's Done output asserts (or a timeout expires), then streams a result window back out of data memory.
- Owns the data-memory port whenever the core is not running.

Parameters:
- MAX_CYCLES, 16'hFFFF: run-cycle limit before timeout; must be ≥1.
- CW, 16: width of cycle_count.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load/run/readback sequence; sampled only in IDLE.
- rd_base  in  8  first data-memory address of the result window; captured on start.
- rd_len  in  8  number of result bytes; captured on start; 0 means no readback.
- ld_valid  in  1  load stream byte valid.
- ld_ready  out  1  load stream ready.
- ld_addr  in  8  data-memory address for the load byte.
- ld_data  in  8  load byte.
- ld_last  in  1  marks the final load byte.
- mem_own  out  1  1 = this block drives the data-memory port; 0 = the core does.
- mem_wr_en  out  1  data-memory write enable.
- mem_rd_en  out  1  data-memory read enable.
- mem_addr  out  8  data-memory address.
- mem_wdata  out  8  data-memory write data.
- mem_rdata  in  8  data-memory read data, combinational from mem_addr.
- core_reset  out  1  active-high reset to the core.
- core_done  in  1  the core's Done output.
- out_valid  out  1  result byte valid.
- out_ready  in  1  result byte accepted.
- out_data  out  8  result byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- timeout  out  1  sticky: last run hit MAX_CYCLES.
- cycle_count  out  CW  number of RUN cycles in the last run.

Behaviour:
- Reset values: state IDLE, core_reset=1, mem_own=1, all enables 0, ld_ready=0, out_valid=0, busy=0, done=0, timeout=0, cycle_count=0, internal index 0.
- Reset mid-sequence aborts immediately to these values. Memory contents are not cleared.
- States: IDLE, LOAD, HOLD, RUN, DRAIN, FIN.
- IDLE:
  - On start=1, capture rd_base and rd_len, clear timeout, go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1.
  - mem_wr_en = ld_valid, mem_addr = ld_addr, mem_wdata = ld_data, all combinational, so the write happens on the handshake edge.
  - On a handshake with ld_last=1, go to HOLD. ld_ready drops the next cycle.
- HOLD:
  - core_reset stays 1 for exactly 2 cycles, then go to RUN.
  - cycle_count is cleared on HOLD entry.
- RUN:
  - core_reset=0, mem_own=0; this block's mem enables are 0.
  - cycle_count increments every RUN cycle, saturating at all-ones.
  - core_done=1 → DRAIN; the cycle in which it is seen is counted.
  - Otherwise, when cycle_count reaches MAX_CYCLES: set timeout=1 → DRAIN.
  - If core_done and the limit coincide, core_done wins and timeout stays 0.
- DRAIN:
  - core_reset=1, mem_own=1.
  - If rd_len=0, go to FIN on the entry cycle with out_valid never asserted.
  - Otherwise mem_rd_en=1, mem_addr = rd_base + idx (mod 256, wraps FF→00), out_data = mem_rdata, out_valid=1.
  - Data stays stable until out_valid && out_ready; then idx increments.
  - After rd_len handshakes, go to FIN.
- FIN: done=1 for one cycle, then IDLE. timeout and cycle_count hold until the next start.
- core_reset=1 in all states except RUN.
- busy=1 in all states except IDLE.

Test Plan:
- Reset low mid-LOAD → all outputs return to reset values within the same cycle; start afterwards runs a full sequence normally.
- Load 3 bytes (addr 10,11,12 = 05,07,00; last on 12), core_done after 9 run cycles, rd_base=12, rd_len=1 → memory written, core_reset low for exactly 9 cycles, cycle_count=9, out_data equals byte at 12, done pulse, timeout=0.
- Readback rd_base=FE, rd_len=3, out_ready toggling 1,0,0,1,1 → mem_addr sequence FE,FF,00; out_data stable through stalls; 3 bytes delivered.
- MAX_CYCLES=20, core_done never asserts → timeout=1, cycle_count=20, DRAIN entered, done pulses.
- rd_len=0 → out_valid never asserted; done 1 cycle after RUN exit.
- start pulsed during RUN and DRAIN → ignored; ld_valid with no handshake outside LOAD → no memory write.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: load / run / readback sequencer in front of the core.
// Preloads data memory, runs the core, then streams a result window.
module run_ctrl #(
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
    parameter int          CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [7:0]    rd_base,
    input  logic [7:0]    rd_len,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          mem_own,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          core_reset,
    input  logic          core_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_e;

    localparam int unsigned LIMIT = MAX_CYCLES;

    state_e        state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic          hold_q, hold_d;
    logic          tmo_q, tmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    // Saturating increment of the run-cycle counter
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured window, index, hold timer, run counter and timeout flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            hold_q <= 1'b0;
            tmo_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        ld_ready   = 1'b0;
        mem_own    = 1'b1;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_reset = 1'b1;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    base_d  = rd_base;
                    len_d   = rd_len;
                    idx_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_wr_en = ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                if (ld_valid && ld_last) begin
                    hold_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = 1'b1;
                end
            end
            S_RUN: begin
                core_reset = 1'b0;
                mem_own    = 1'b0;
                cnt_d      = cnt_inc;
                if (core_done) begin
                    state_d = S_DRAIN;
                end else if (32'(cnt_inc) >= LIMIT) begin
                    tmo_d   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (len_q == 8'd0) begin
                    state_d = S_FIN;
                end else begin
                    mem_rd_en = 1'b1;
                    mem_addr  = base_q + idx_q;
                    out_data  = mem_rdata;
                    out_valid = 1'b1;
                    if (out_ready) begin
                        idx_d = idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign timeout     = tmo_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboard bench for run_ctrl.
// Memory and core are modelled here; readback bytes are checked in order.
module tb_run_ctrl;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [7:0]  rd_base;
    logic [7:0]  rd_len;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        mem_own;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        core_reset;
    logic        core_done;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    run_ctrl #(
        .MAX_CYCLES(16'd20),
        .CW        (16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_own    (mem_own),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .core_reset (core_reset),
        .core_done  (core_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_q   [$];
    logic [7:0]  ld_a    [$];
    logic [7:0]  ld_d    [$];

    int done_at = 0;
    int rc      = 0;
    int nwr     = 0;
    int nout    = 0;
    int nvalid  = 0;
    int rp      = 0;
    bit use_pat = 0;
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit held    = 0;
    logic [7:0] held_d;
    logic [7:0] held_a;
    logic [15:0] e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory: synchronous write, combinational read
    always @(posedge Clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wdata;
            nwr++;
        end
    end
    assign mem_rdata = mem[mem_addr];

    // Core stand-in: raises Done in its done_at-th cycle out of reset
    always @(posedge Clk) begin
        rc <= core_reset ? 0 : rc + 1;
    end
    assign core_done = (done_at != 0) && !core_reset && (rc == done_at - 1);

    // Result consumer: ready either always high or from the stall pattern
    always begin
        @(posedge Clk);
        #1;
        if (!use_pat) begin
            out_ready = 1'b1;
        end else begin
            out_ready = pat[rp % 5];
            if (out_valid) rp++;
        end
    end

    // Readback monitor: stability on stalls, scoreboard on handshakes
    always @(negedge Clk) begin
        if (Reset && out_valid) begin
            nvalid++;
            if (held) begin
                chk("stable_d", out_data, held_d);
                chk("stable_a", mem_addr, held_a);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("raddr", mem_addr, e[15:8]);
                    chk("rdata", out_data, e[7:0]);
                end
                nout++;
                held = 0;
            end else begin
                held   = 1;
                held_d = out_data;
                held_a = mem_addr;
            end
        end else begin
            held = 0;
        end
    end

    task automatic run_seq(input logic [7:0] base, input logic [7:0] len,
                           input int dat, input bit inj,
                           input logic exp_to, input int exp_cnt);
        int k;
        int holdc;
        int lowc;
        int ndone;
        int last_run;
        int done_cyc;
        bit seen_run;
        bit ijd;
        logic [7:0] a;
        @(negedge Clk);
        done_at = dat;
        nout    = 0;
        nvalid  = 0;
        nwr     = 0;
        rp      = 0;
        rd_base = base;
        rd_len  = len;
        start   = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("busy", busy, 1);
        for (int i = 0; i < ld_a.size(); i++) begin
            ld_valid = 1'b1;
            ld_addr  = ld_a[i];
            ld_data  = ld_d[i];
            ld_last  = (i == ld_a.size() - 1);
            k = 0;
            while (!ld_ready && k < 20) begin
                @(negedge Clk);
                k++;
            end
            chk("ldrdy", ld_ready, 1);
            ref_mem[ld_a[i]] = ld_d[i];
            @(negedge Clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            exp_q.push_back({a, ref_mem[a]});
        end
        holdc    = 0;
        lowc     = 0;
        ndone    = 0;
        last_run = -1;
        done_cyc = -1;
        seen_run = 0;
        ijd      = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (core_reset && !seen_run) holdc++;
            if (!core_reset) begin
                seen_run = 1;
                lowc++;
                last_run = cyc;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            start    = 1'b0;
            ld_valid = 1'b0;
            if (inj && !core_reset && lowc == 3) begin
                start    = 1'b1;
                rd_base  = base + 8'h40;
                rd_len   = 8'h07;
                ld_valid = 1'b1;
                ld_addr  = base;
                ld_data  = ~ref_mem[base];
            end else if (inj && out_valid && !ijd) begin
                ijd      = 1;
                start    = 1'b1;
                ld_valid = 1'b1;
                ld_addr  = base + 8'd1;
                ld_data  = ~ref_mem[base + 8'd1];
            end
            if (done) break;
            @(negedge Clk);
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        chk("ndone", ndone, 1);
        @(negedge Clk);
        chk("pulse", done, 0);
        chk("idle", busy, 0);
        chk("tmo", timeout, exp_to);
        chk("ccnt", cycle_count, exp_cnt);
        chk("lowc", lowc, exp_cnt);
        chk("hold", holdc, 2);
        chk("nout", nout, len);
        chk("nwr", nwr, ld_a.size());
        chk("qleft", exp_q.size(), 0);
        if (len == 8'd0) begin
            chk("noval", nvalid, 0);
            chk("lat", done_cyc - last_run, 2);
        end
        exp_q.delete();
        ld_a.delete();
        ld_d.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        Reset    = 1'b0;
        start    = 1'b0;
        rd_base  = '0;
        rd_len   = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_last  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_busy", busy, 0);
        chk("rst_crst", core_reset, 1);
        chk("rst_own", mem_own, 1);
        chk("rst_rdy", ld_ready, 0);
        chk("rst_cnt", cycle_count, 0);
        Reset = 1'b1;

        ld_a = '{8'd10, 8'd11, 8'd12};
        ld_d = '{8'h05, 8'h07, 8'h00};
        run_seq(8'd12, 8'd1, 9, 0, 1'b0, 9);

        use_pat = 1;
        ld_a = '{8'hFE, 8'hFF, 8'h00};
        ld_d = '{8'hA1, 8'hB2, 8'hC3};
        run_seq(8'hFE, 8'd3, 5, 0, 1'b0, 5);
        use_pat = 0;

        ld_a = '{8'h40};
        ld_d = '{8'h11};
        run_seq(8'h40, 8'd2, 0, 0, 1'b1, 20);

        @(negedge Clk);
        rd_base = 8'h30;
        rd_len  = 8'd1;
        start   = 1'b1;
        @(negedge Clk);
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 8'h30;
        ld_data  = 8'h77;
        ld_last  = 1'b0;
        @(negedge Clk);
        ref_mem[8'h30] = 8'h77;
        ld_valid = 1'b0;
        chk("pre_busy", busy, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_rdy", ld_ready, 0);
        chk("mid_crst", core_reset, 1);
        chk("mid_own", mem_own, 1);
        chk("mid_wr", mem_wr_en, 0);
        chk("mid_tmo", timeout, 0);
        chk("mid_cnt", cycle_count, 0);
        chk("mid_ov", out_valid, 0);
        @(negedge Clk);
        Reset = 1'b1;

        ld_a = '{8'h50};
        ld_d = '{8'h99};
        run_seq(8'h2F, 8'd2, 20, 0, 1'b0, 20);

        ld_a = '{8'h60};
        ld_d = '{8'h01};
        run_seq(8'h60, 8'd0, 3, 0, 1'b0, 3);

        ld_a = '{8'h70, 8'h71};
        ld_d = '{8'hAB, 8'hCD};
        run_seq(8'h70, 8'd2, 6, 1, 1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
